// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a small byte FIFO that a
// serialiser FSM drains onto tx, and a status word is readable combinationally.
module mmio_uart_tx #(
    parameter logic [31:0] ADDR_TX      = 32'hFFFF_0000,
    parameter logic [31:0] ADDR_STAT    = 32'hFFFF_0004,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   DepthVal = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [2:0]        idxQ, idxD;
    logic [7:0]        shregQ, shregD;
    logic              txQ, txD;
    logic [PtrW:0]     countQ, countD;
    logic [PtrW-1:0]   wrPtrQ, rdPtrQ;
    logic              overflowQ, overflowD;
    logic [7:0]        mem [FIFO_DEPTH];

    logic wrTx, wrStat, full, empty, pop, accept, drop;
    logic [3:0] countStat;

    assign wrTx   = MemWrite && (DataAdr == ADDR_TX);
    assign wrStat = MemWrite && (DataAdr == ADDR_STAT);
    assign full   = (countQ == DepthVal);
    assign empty  = (countQ == '0);
    assign pop    = (stateQ == StIdle) && !empty;
    // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
    assign accept = wrTx && (!full || pop);
    assign drop   = wrTx && !accept;

    always_comb begin
        countD = countQ;
        if (accept && !pop) begin
            countD = countQ + 1'b1;
        end else if (!accept && pop) begin
            countD = countQ - 1'b1;
        end
    end

    // Set beats clear when both happen in one edge.
    always_comb begin
        overflowD = overflowQ;
        if (wrStat && WriteData[0]) begin
            overflowD = 1'b0;
        end
        if (drop) begin
            overflowD = 1'b1;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        idxD   = idxQ;
        shregD = shregQ;
        txD    = txQ;
        unique case (stateQ)
            StIdle: begin
                txD = 1'b1;
                if (pop) begin
                    shregD = mem[rdPtrQ];
                    cntD   = '0;
                    stateD = StStart;
                    txD    = 1'b0;
                end
            end
            StStart: begin
                if (cntQ == BitLast) begin
                    cntD   = '0;
                    idxD   = '0;
                    stateD = StData;
                    txD    = shregQ[0];
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            StData: begin
                if (cntQ == BitLast) begin
                    cntD   = '0;
                    shregD = shregQ >> 1;
                    if (idxQ == 3'd7) begin
                        stateD = StStop;
                        txD    = 1'b1;
                    end else begin
                        idxD = idxQ + 1'b1;
                        txD  = shregQ[1];
                    end
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            StStop: begin
                txD = 1'b1;
                if (cntQ == BitLast) begin
                    cntD   = '0;
                    stateD = StIdle;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            default: begin
                stateD = StIdle;
                txD    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            cntQ      <= '0;
            idxQ      <= '0;
            shregQ    <= '0;
            txQ       <= 1'b1;
            countQ    <= '0;
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            idxQ      <= idxD;
            shregQ    <= shregD;
            txQ       <= txD;
            countQ    <= countD;
            overflowQ <= overflowD;
            if (accept) begin
                wrPtrQ <= wrPtrQ + 1'b1;
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[wrPtrQ] <= WriteData[7:0];
        end
    end

    assign countStat = 4'(countQ);
    assign tx        = txQ;
    assign tx_busy   = (stateQ != StIdle) || !empty;
    assign ReadData  = (DataAdr == ADDR_STAT) ?
                       {24'b0, countStat, 1'b0, overflowQ, full, tx_busy} : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: frame timing, FIFO overflow, status/clear,
// mid-frame reset and address decoding, with immediate-assertion checks.
module tb_mmio_uart_tx;

    localparam logic [31:0] ADDR_TX   = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STAT = 32'hFFFF_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        tx_busy;

    int tests = 0;
    int fails = 0;

    mmio_uart_tx #(
        .ADDR_TX      (ADDR_TX),
        .ADDR_STAT    (ADDR_STAT),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after edge P+jStart-1, where P is the pop edge.
    task automatic checkFrame(input logic [7:0] b, input int jStart, input string tag);
        logic expTx;
        for (int j = jStart; j < 40; j++) begin
            @(negedge clk);
            if (j < 4) expTx = 1'b0;
            else if (j < 36) expTx = b[(j - 4) / 4];
            else expTx = 1'b1;
            check($sformatf("%s tx j%0d", tag, j), {31'b0, tx}, {31'b0, expTx});
        end
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;

        // 1: reset state
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("t1 tx", {31'b0, tx}, 32'h1);
        check("t1 busy", {31'b0, tx_busy}, 32'h0);
        DataAdr = ADDR_STAT;
        #1 check("t1 stat", ReadData, 32'h0);
        DataAdr = ADDR_TX;
        #1 check("t1 txadr read", ReadData, 32'h0);

        // 2: single frame of 0x55
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = ADDR_TX;
        WriteData = 32'h55;
        @(negedge clk);
        MemWrite = 1'b0;
        DataAdr  = ADDR_STAT;
        #1 check("t2 stat after push", ReadData, 32'h11);
        check("t2 tx before pop", {31'b0, tx}, 32'h1);
        checkFrame(8'h55, 0, "t2");
        check("t2 busy in stop", {31'b0, tx_busy}, 32'h1);
        @(negedge clk);
        check("t2 busy fall", {31'b0, tx_busy}, 32'h0);
        check("t2 tx idle", {31'b0, tx}, 32'h1);
        check("t2 stat idle", ReadData, 32'h0);

        // 3: six back-to-back stores, sixth overflows
        for (int i = 0; i < 6; i++) begin
            MemWrite  = 1'b1;
            DataAdr   = ADDR_TX;
            WriteData = 32'(i + 1);
            @(negedge clk);
            check($sformatf("t3 tx push%0d", i), {31'b0, tx},
                  (i == 0 || i == 5) ? 32'h1 : 32'h0);
        end
        MemWrite = 1'b0;
        DataAdr  = ADDR_STAT;
        #1 check("t3 stat full+ovf", ReadData, 32'h47);
        DataAdr = ADDR_TX;
        #1 check("t3 read non-stat", ReadData, 32'h0);
        DataAdr = ADDR_STAT;
        checkFrame(8'h01, 5, "t3 b1");
        for (int b = 2; b <= 5; b++) begin
            @(negedge clk);
            check($sformatf("t3 idle gap %0d", b), {31'b0, tx}, 32'h1);
            checkFrame(8'(b), 0, $sformatf("t3 b%0d", b));
        end
        @(negedge clk);
        check("t3 tx end", {31'b0, tx}, 32'h1);
        check("t3 busy end", {31'b0, tx_busy}, 32'h0);
        #1 check("t3 stat ovf sticky", ReadData, 32'h04);

        // 4: overflow clear
        MemWrite  = 1'b1;
        DataAdr   = ADDR_STAT;
        WriteData = 32'h0;
        @(negedge clk);
        MemWrite = 1'b0;
        #1 check("t4 clear bit0=0", ReadData, 32'h04);
        MemWrite  = 1'b1;
        DataAdr   = 32'hFFFF_0005;
        WriteData = 32'h1;
        @(negedge clk);
        MemWrite = 1'b0;
        DataAdr  = ADDR_STAT;
        #1 check("t4 clear misaligned", ReadData, 32'h04);
        MemWrite  = 1'b1;
        WriteData = 32'h1;
        @(negedge clk);
        MemWrite = 1'b0;
        #1 check("t4 clear", ReadData, 32'h00);

        // 5: reset during data bit 3, with a second byte queued
        MemWrite  = 1'b1;
        DataAdr   = ADDR_TX;
        WriteData = 32'hA5;
        @(negedge clk);
        WriteData = 32'h3C;
        @(negedge clk);
        MemWrite = 1'b0;
        DataAdr  = ADDR_STAT;
        repeat (17) @(negedge clk);
        check("t5 tx bit3", {31'b0, tx}, 32'h0);
        check("t5 busy pre", {31'b0, tx_busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5 tx reset", {31'b0, tx}, 32'h1);
        check("t5 busy reset", {31'b0, tx_busy}, 32'h0);
        #1 check("t5 stat reset", ReadData, 32'h0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check($sformatf("t5 tx quiet %0d", k), {31'b0, tx}, 32'h1);
        end
        check("t5 stat quiet", ReadData, 32'h0);

        // 6: non-matching stores
        MemWrite  = 1'b1;
        DataAdr   = 32'hFFFF_0008;
        WriteData = 32'h77;
        @(negedge clk);
        MemWrite = 1'b0;
        DataAdr  = ADDR_TX;
        @(negedge clk);
        MemWrite = 1'b1;
        DataAdr  = 32'hFFFF_0001;
        @(negedge clk);
        MemWrite = 1'b0;
        DataAdr  = ADDR_STAT;
        #1 check("t6 stat", ReadData, 32'h0);
        check("t6 busy", {31'b0, tx_busy}, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t6 tx %0d", k), {31'b0, tx}, 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
